// File: rtl/display_scan_mux.sv
// Two-digit common-anode 7-segment scanner for a 0..15 code, with per-slot blanking guard.
// Optional: LEADING_ZERO_BLANK_EN keeps the tens digit dark when it would show "0".
module display_scan_mux #(
   parameter int REFRESH_DIV = 27000,
   parameter int GUARD       = 270
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] binary_code,
   output logic [6:0] seg_n,
   output logic [1:0] an_n,
   output logic       frame_done
);

   localparam int CW = $clog2(REFRESH_DIV);

   typedef enum logic [1:0] {S_GUARD_U, S_SHOW_U, S_GUARD_T, S_SHOW_T} state_t;

   state_t       state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]   val_q, val_d;
   logic [1:0]   an_n_q, an_n_d;
   logic [6:0]   seg_n_q, seg_n_d;
   logic         wrap_q, wrap_d;
   logic         frame_done_q, frame_done_d;

   logic         slot_end, guard_end, tens;
   logic [3:0]   units;

   function automatic logic [6:0] pattern(input logic [3:0] d);
      case (d)
         4'd0:    pattern = 7'b1000000;
         4'd1:    pattern = 7'b1111001;
         4'd2:    pattern = 7'b0100100;
         4'd3:    pattern = 7'b0110000;
         4'd4:    pattern = 7'b0011001;
         4'd5:    pattern = 7'b0010010;
         4'd6:    pattern = 7'b0000010;
         4'd7:    pattern = 7'b1111000;
         4'd8:    pattern = 7'b0000000;
         4'd9:    pattern = 7'b0010000;
         default: pattern = 7'h7F;
      endcase
   endfunction

   always_comb begin
      slot_end  = (cnt_q == CW'(REFRESH_DIV - 1));
      guard_end = (cnt_q == CW'(GUARD - 1));
      tens      = (val_q >= 4'd10);
      units     = tens ? (val_q - 4'd10) : val_q;

      cnt_d   = slot_end ? '0 : cnt_q + CW'(1);
      state_d = state_q;
      val_d   = val_q;
      wrap_d  = 1'b0;
      an_n_d  = 2'b11;
      seg_n_d = 7'h7F;

      case (state_q)
         S_GUARD_U: if (guard_end) state_d = S_SHOW_U;
         S_SHOW_U: begin
            an_n_d  = 2'b10;
            seg_n_d = pattern(units);
            if (slot_end) state_d = S_GUARD_T;
         end
         S_GUARD_T: if (guard_end) state_d = S_SHOW_T;
         S_SHOW_T: begin
`ifdef LEADING_ZERO_BLANK_EN
            if (tens) begin
               an_n_d  = 2'b01;
               seg_n_d = pattern(4'd1);
            end
`else
            an_n_d  = 2'b01;
            seg_n_d = pattern({3'b000, tens});
`endif
            if (slot_end) begin
               // Frame boundary: latch the next value so a whole frame shows one code
               state_d = S_GUARD_U;
               val_d   = binary_code;
               wrap_d  = 1'b1;
            end
         end
         default: state_d = S_GUARD_U;
      endcase

      // Delayed one extra cycle so the pulse coincides with the outputs going blank
      frame_done_d = wrap_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_GUARD_U;
         cnt_q        <= '0;
         val_q        <= 4'd0;
         an_n_q       <= 2'b11;
         seg_n_q      <= 7'h7F;
         wrap_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         val_q        <= val_d;
         an_n_q       <= an_n_d;
         seg_n_q      <= seg_n_d;
         wrap_q       <= wrap_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign an_n       = an_n_q;
   assign seg_n      = seg_n_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Randomised bench for display_scan_mux, checked against a frame-position model.
module tb_display_scan_mux;

   localparam int RD    = 8;
   localparam int GD    = 2;
   localparam int FRAME = 2 * RD;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] binary_code = 4'd0;
   logic [6:0] seg_n;
   logic [1:0] an_n;
   logic       frame_done;

   int n_chk  = 0;
   int n_fail = 0;
   int k      = 0;      // rising edges since reset released
   int mval   = 0;      // value the model is displaying
   int pulses = 0;
   logic [6:0] pat [10];

   display_scan_mux #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
      .clk(clk), .rst(rst), .binary_code(binary_code),
      .seg_n(seg_n), .an_n(an_n), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%0h exp=%0h k=%0d", tag, obs, exp, k);
      end
   endtask

   // Display content for a given position inside the frame
   task automatic exp_out(input int pos, input int v, output logic [1:0] ea, output logic [6:0] es);
      int slot, w;
      slot = pos / RD;
      w    = pos % RD;
      ea = 2'b11;
      es = 7'h7F;
      if (w >= GD) begin
         if (slot == 0) begin
            ea = 2'b10;
            es = pat[v % 10];
         end else begin
`ifdef LEADING_ZERO_BLANK_EN
            if (v >= 10) begin
               ea = 2'b01;
               es = pat[1];
            end
`else
            ea = 2'b01;
            es = pat[v / 10];
`endif
         end
      end
   endtask

   task automatic cyc(input logic r, input logic [3:0] code);
      logic [1:0] ea;
      logic [6:0] es;
      logic       ef;
      int         pos;
      rst = r;
      binary_code = code;
      @(posedge clk);
      if (r) begin
         k = 0; mval = 0; ea = 2'b11; es = 7'h7F; ef = 1'b0;
      end else begin
         pos = k % FRAME;
         exp_out(pos, mval, ea, es);
         ef = (k >= FRAME) && (k % FRAME == 0);
         if (pos == FRAME - 1) mval = int'(code);
         k++;
      end
      @(negedge clk);
      chk("an_n", 32'(an_n), 32'(ea));
      chk("seg_n", 32'(seg_n), 32'(es));
      chk("frame_done", 32'(frame_done), 32'(ef));
      chk("an_both_low", 32'(an_n == 2'b00), 32'(0));
      if (frame_done) pulses++;
   endtask

   initial begin
      pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
      pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
      pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
      pat[9] = 7'b0010000;

      @(negedge clk);
      // reset, then 13 held: first frame shows 0, second shows 13
      repeat (3) cyc(1'b1, 4'd13);
      repeat (2 * FRAME) cyc(1'b0, 4'd13);

      // latch 7, change to 12 mid-frame
      cyc(1'b0, 4'd7);
      while (k % FRAME != 0) cyc(1'b0, 4'd7);
      repeat (5) cyc(1'b0, 4'd7);
      repeat (2 * FRAME + 3) cyc(1'b0, 4'd12);

      // free run, one frame_done per frame
      while (k % FRAME != 0) cyc(1'b0, 4'd12);
      pulses = 0;
      repeat (10 * FRAME) cyc(1'b0, 4'd9);
      chk("pulse_count", 32'(pulses), 32'(10));

      // reset during the tens slot
      while (k % FRAME != RD + GD + 2) cyc(1'b0, 4'd9);
      cyc(1'b1, 4'd9);
      repeat (2 * FRAME + 4) cyc(1'b0, 4'd9);

      // single-digit value, tens slot behaviour
      repeat (3 * FRAME) cyc(1'b0, 4'd4);

      // random codes and occasional resets
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 7) == 0) binary_code = 4'($urandom_range(0, 15));
         cyc(($urandom_range(0, 299) == 0), binary_code);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
